// File: rtl/lb_conv_window.sv
// Sweeps the buffered row set column by column, keeps a ROWS x ROWS sliding window
// and emits one signed convolution result per window position on a valid/ready port.
module lb_conv_window #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 3,
    parameter int ROW_WIDTH  = 5,
    parameter int COEF_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(ROW_WIDTH),
    parameter int OUT_WIDTH  = DATA_WIDTH + COEF_WIDTH + 1 + $clog2(ROWS * ROWS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [ADDR_WIDTH-1:0]               add_r,
    output logic                                r_en,
    input  logic [ROWS*DATA_WIDTH-1:0]          col_in,
    input  logic [ROWS*ROWS*COEF_WIDTH-1:0]     coef,
    output logic signed [OUT_WIDTH-1:0]         out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                row_done
);

    // state   | meaning
    // S_IDLE  | waiting for start; a final result may still await handshake
    // S_READ  | sweeping columns, one per accepted advance
    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Only the ROWS-1 newest columns are kept; the live col_in completes the window.
    logic [DATA_WIDTH-1:0] r_hist [ROWS][ROWS-1];

    logic                        w_advance;
    logic                        w_last;
    logic                        w_emit;
    logic signed [OUT_WIDTH-1:0] w_sum;

    function automatic logic signed [OUT_WIDTH-1:0] mac_term(
        input logic [COEF_WIDTH-1:0] c,
        input logic [DATA_WIDTH-1:0] p
    );
        logic signed [OUT_WIDTH-1:0] c_ext;
        logic signed [OUT_WIDTH-1:0] p_ext;
        c_ext = {{(OUT_WIDTH-COEF_WIDTH){c[COEF_WIDTH-1]}}, c};
        p_ext = {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, p};
        return c_ext * p_ext;
    endfunction

    assign w_advance = (r_state == S_READ) && (!out_valid || out_ready);
    assign w_last    = (add_r == ADDR_WIDTH'(ROW_WIDTH - 1));
    assign w_emit    = (add_r >= ADDR_WIDTH'(ROWS - 1));
    assign r_en      = (r_state == S_READ);
    assign busy      = (r_state == S_READ);

    always_comb begin
        w_sum = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < ROWS - 1; k++) begin
                w_sum = w_sum + mac_term(coef[(r*ROWS+k)*COEF_WIDTH +: COEF_WIDTH], r_hist[r][k]);
            end
            w_sum = w_sum + mac_term(coef[(r*ROWS+ROWS-1)*COEF_WIDTH +: COEF_WIDTH],
                                     col_in[r*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_READ;
            S_READ: if (w_advance && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            add_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            row_done  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < ROWS - 1; j++) begin
                    r_hist[r][j] <= '0;
                end
            end
        end else begin
            r_state  <= w_state_nxt;
            row_done <= w_advance && w_last;

            if (r_state == S_IDLE && start) begin
                add_r <= '0;
            end else if (w_advance) begin
                add_r <= w_last ? '0 : add_r + ADDR_WIDTH'(1);
            end

            if (w_advance) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int j = 0; j < ROWS - 2; j++) begin
                        r_hist[r][j] <= r_hist[r][j+1];
                    end
                    r_hist[r][ROWS-2] <= col_in[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // A stall (valid && !ready) blocks advance, so the held result is never overwritten.
            if (w_advance && w_emit) begin
                out_valid <= 1'b1;
                out_data  <= w_sum;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lb_conv_window.sv
// Directed bench for lb_conv_window: a behavioural line buffer answers reads from
// a pixel array, and each sweep's results and timing are compared to hand values.
module tb_lb_conv_window;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 5;
    localparam int KW = 8;
    localparam int AW = $clog2(CW);
    localparam int OW = DW + KW + 1 + $clog2(RW * RW);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [AW-1:0]             add_r;
    logic                      r_en;
    logic [RW*DW-1:0]          col_in;
    logic [RW*RW*KW-1:0]       coef;
    logic signed [OW-1:0]      out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;
    logic                      row_done;

    logic [DW-1:0]        pix [RW][CW];
    logic signed [KW-1:0] cf  [RW*RW];

    int n_vec = 0;
    int n_err = 0;

    logic signed [31:0] got [$];
    int                 hs [$];
    logic signed [31:0] held [$];
    int                 addr_stall [$];
    int                 n_rd;
    int                 rd_cyc;
    int                 busy_low;
    int                 a1;
    int                 e1;

    lb_conv_window dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .add_r     (add_r),
        .r_en      (r_en),
        .col_in    (col_in),
        .coef      (coef),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .row_done  (row_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = '0;
        for (int i = 0; i < RW; i++) begin
            if (int'(add_r) < CW) col_in[i*DW +: DW] = pix[i][int'(add_r)];
        end
    end

    always_comb begin
        coef = '0;
        for (int i = 0; i < RW*RW; i++) coef[i*KW +: KW] = cf[i];
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode, input int c_all, input int c_center);
        for (int r = 0; r < RW; r++)
            for (int c = 0; c < CW; c++)
                pix[r][c] = (mode == 0) ? 8'd1 : (mode == 1) ? 8'(10*r + c) : 8'd255;
        for (int i = 0; i < RW*RW; i++) cf[i] = KW'(c_all);
        cf[4] = KW'(c_center);
    endtask

    // Called at a negedge; cycle c is the observation after the c-th edge counting the start edge.
    task automatic run(input int stall_lo, input int stall_hi, input int restart_at, input int rst_at);
        got.delete(); hs.delete(); held.delete(); addr_stall.delete();
        n_rd = 0; rd_cyc = -1; busy_low = -1; a1 = -1; e1 = -1;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start     = (c == restart_at);
            out_ready = !(c >= stall_lo && c <= stall_hi);
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 1) begin
                chk("rst_add_r",     32'(add_r),     0);
                chk("rst_r_en",      32'(r_en),      0);
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_out_data",  32'(out_data),  0);
                chk("rst_busy",      32'(busy),      0);
                chk("rst_row_done",  32'(row_done),  0);
                rst = 1'b0;
            end
            if (c == 1) begin a1 = int'(add_r); e1 = int'(r_en); end
            if (out_valid && out_ready && !rst) begin
                got.push_back(32'(out_data));
                hs.push_back(c);
            end
            if (c >= stall_lo && c <= stall_hi) begin
                addr_stall.push_back(int'(add_r));
                held.push_back(32'(out_data));
            end
            if (row_done) begin n_rd++; rd_cyc = c; end
            if (!busy && busy_low < 0) busy_low = c;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        fill(0, 1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_add_r",     32'(add_r),     0);
        chk("reset_r_en",      32'(r_en),      0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data",  32'(out_data),  0);
        chk("reset_busy",      32'(busy),      0);
        chk("reset_row_done",  32'(row_done),  0);

        // all ones: 9,9,9 at cycles 4..6, row_done and busy low at 6
        run(0, -1, -1, -5);
        chk("ones_addr_c1", a1, 0);
        chk("ones_ren_c1",  e1, 1);
        chk("ones_count",   got.size(), 3);
        chk("ones_out0",    got[0], 9);
        chk("ones_out1",    got[1], 9);
        chk("ones_out2",    got[2], 9);
        chk("ones_first_cyc", hs[0], 4);
        chk("ones_last_cyc",  hs[2], 6);
        chk("ones_rd_cyc",    rd_cyc, 6);
        chk("ones_rd_cnt",    n_rd, 1);
        chk("ones_busy_low",  busy_low, 6);

        // identity kernel on 10*row+col picks the window centre
        fill(1, 0, 1);
        run(0, -1, -1, -5);
        chk("ident_count", got.size(), 3);
        chk("ident_out0",  got[0], 11);
        chk("ident_out1",  got[1], 12);
        chk("ident_out2",  got[2], 13);

        // extreme magnitude: 9 * 255 * -1
        fill(2, -1, -1);
        run(0, -1, -1, -5);
        chk("neg_count", got.size(), 3);
        chk("neg_out0",  got[0], -2295);
        chk("neg_out2",  got[2], -2295);

        // back-pressure for cycles 4..6
        fill(0, 1, 1);
        run(4, 6, -1, -5);
        chk("stall_count",  got.size(), 3);
        chk("stall_out0",   got[0], 9);
        chk("stall_out2",   got[2], 9);
        chk("stall_addr0",  addr_stall[0], 3);
        chk("stall_addr2",  addr_stall[2], 3);
        chk("stall_held0",  held[0], 9);
        chk("stall_held2",  held[2], 9);
        chk("stall_hs0",    hs[0], 7);
        chk("stall_rd_cyc", rd_cyc, 9);
        chk("stall_rd_cnt", n_rd, 1);

        // reset mid-sweep, then a clean sweep
        run(0, -1, -1, 3);
        chk("rst_sweep_count", got.size(), 0);
        chk("rst_sweep_rd",    n_rd, 0);
        run(0, -1, -1, -5);
        chk("post_rst_count",  got.size(), 3);
        chk("post_rst_out2",   got[2], 9);
        chk("post_rst_rd_cyc", rd_cyc, 6);

        // start while busy is ignored
        run(0, -1, 2, -5);
        chk("restart_count",  got.size(), 3);
        chk("restart_rd_cnt", n_rd, 1);
        chk("restart_rd_cyc", rd_cyc, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
